// File: rtl/screen_pkg.sv
// Shared types and constants for the 40x30 character screen update path.
package screen_pkg;

    localparam int unsigned SCREEN_COLS = 40;
    localparam int unsigned SCREEN_ROWS = 30;
    localparam int unsigned NCELLS      = SCREEN_COLS * SCREEN_ROWS;
    localparam int unsigned ABITS       = 11;
    localparam int unsigned CBITS       = 4;
    localparam int unsigned WR_BITS     = ABITS + CBITS;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        CLEAR
    } suc_state_t;

    typedef struct packed {
        logic [ABITS-1:0] addr;
        logic [CBITS-1:0] code;
    } char_wr_t;

    // True when an address names a visible cell.
    function automatic logic on_screen(input logic [ABITS-1:0] a);
        return (a < ABITS'(NCELLS));
    endfunction

endpackage

// File: rtl/char_write_fifo.sv
// Synchronous FIFO buffering CPU character writes until vertical blank.
module char_write_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 15
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (do_pop && !do_push) count <= count - CW'(1);
        end
    end

    // Storage needs no reset; pointers and count define validity.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/screen_update_controller.sv
// Commits buffered CPU writes and whole-screen clears only during vertical blank.
module screen_update_controller
    import screen_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   vblank,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [ABITS-1:0]       wr_addr,
    input  logic [CBITS-1:0]       wr_char,
    input  logic                   clr_req,
    input  logic [CBITS-1:0]       clr_char,
    output logic                   smem_we,
    output logic [ABITS-1:0]       smem_addr,
    output logic [CBITS-1:0]       smem_wdata,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    suc_state_t       state;
    suc_state_t       state_nxt;
    logic             clear_pending;
    logic [CBITS-1:0] fill_char;
    logic [ABITS-1:0] counter;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             clr_done;
    logic             cnt_inc;
    char_wr_t         wr_entry;
    char_wr_t         head;

    assign wr_entry = '{addr: wr_addr, code: wr_char};
    assign wr_ready = !full;
    assign push     = wr_valid && wr_ready;
    assign busy     = clear_pending || (fifo_count != '0);

    char_write_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WR_BITS)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (wr_entry),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, FIFO pop and the screen-memory write port.
    always_comb begin
        state_nxt  = state;
        pop        = 1'b0;
        clr_done   = 1'b0;
        cnt_inc    = 1'b0;
        smem_we    = 1'b0;
        smem_addr  = '0;
        smem_wdata = '0;
        case (state)
            IDLE: begin
                if (clear_pending)  state_nxt = CLEAR;
                else if (!empty)    state_nxt = DRAIN;
            end
            DRAIN: begin
                // A pending clear preempts at the entry boundary, before any pop.
                if (clear_pending) begin
                    state_nxt = CLEAR;
                end else if (empty) begin
                    state_nxt = IDLE;
                end else if (vblank) begin
                    pop = 1'b1;
                    if (on_screen(head.addr)) begin
                        smem_we    = 1'b1;
                        smem_addr  = head.addr;
                        smem_wdata = head.code;
                    end
                    if ((fifo_count == CW'(1)) && !push) state_nxt = IDLE;
                end
            end
            CLEAR: begin
                if (vblank) begin
                    smem_we    = 1'b1;
                    smem_addr  = counter;
                    smem_wdata = fill_char;
                    if (counter == ABITS'(NCELLS - 1)) begin
                        clr_done  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Clear bookkeeping: a request while one is pending is ignored.
    always_ff @(posedge clock) begin
        if (reset) begin
            clear_pending <= 1'b0;
            fill_char     <= '0;
            counter       <= '0;
        end else begin
            if (clr_done)     counter <= '0;
            else if (cnt_inc) counter <= counter + ABITS'(1);

            if (clr_done) begin
                clear_pending <= 1'b0;
            end else if (clr_req && !clear_pending) begin
                clear_pending <= 1'b1;
                fill_char     <= clr_char;
            end
        end
    end

endmodule

// File: tb/tb_screen_update_controller.sv
// Directed self-checking bench for screen_update_controller.
module tb_screen_update_controller;
    import screen_pkg::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic             clock;
    logic             reset;
    logic             vblank;
    logic             wr_valid;
    logic             wr_ready;
    logic [ABITS-1:0] wr_addr;
    logic [CBITS-1:0] wr_char;
    logic             clr_req;
    logic [CBITS-1:0] clr_char;
    logic             smem_we;
    logic [ABITS-1:0] smem_addr;
    logic [CBITS-1:0] smem_wdata;
    logic             busy;
    logic [CW-1:0]    fifo_count;

    int checks;
    int passes;
    int fails;
    int n;
    int gap;
    int errs;
    logic done;
    logic pause_now;
    logic paused;
    logic pushed;
    logic busy_mid;
    logic rdy [9];
    logic [ABITS-1:0] ga [$];
    logic [CBITS-1:0] gd [$];
    logic [ABITS-1:0] last_a;
    logic [CBITS-1:0] last_d;

    screen_update_controller #(.DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .vblank     (vblank),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_char    (wr_char),
        .clr_req    (clr_req),
        .clr_char   (clr_char),
        .smem_we    (smem_we),
        .smem_addr  (smem_addr),
        .smem_wdata (smem_wdata),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input logic [ABITS-1:0] a, input logic [CBITS-1:0] d);
        chk(tag, 32'({smem_we, smem_addr, smem_wdata}), 32'({1'b1, a, d}));
    endtask

    task automatic adv();
        @(posedge clock);
        #1;
    endtask

    task automatic collect();
        if (smem_we) begin
            ga.push_back(smem_addr);
            gd.push_back(smem_wdata);
        end
    endtask

    initial begin
        checks = 0; passes = 0; fails = 0;
        reset = 1'b1; vblank = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_char = '0;
        clr_req = 1'b0; clr_char = '0;

        // Reset values
        adv(); adv();
        @(negedge clock);
        chk("rst_smem", 32'({smem_we, smem_addr, smem_wdata}), 32'(0));
        chk("rst_ready", 32'(wr_ready), 32'(1));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_count", 32'(fifo_count), 32'(0));
        adv();
        reset = 1'b0;
        n = 0;
        repeat (10) begin @(negedge clock); if (smem_we) n++; adv(); end
        chk("idle_no_we", 32'(n), 32'(0));

        // Two writes held off by active display, then committed in vblank
        vblank = 1'b0;
        wr_valid = 1'b1; wr_addr = 11'd41; wr_char = 4'd5;
        @(negedge clock);
        chk("t2_ready", 32'(wr_ready), 32'(1));
        adv();
        wr_addr = 11'd1199; wr_char = 4'd3;
        adv();
        wr_valid = 1'b0;
        n = 0;
        repeat (5) begin @(negedge clock); if (smem_we) n++; adv(); end
        chk("t2_no_we_active", 32'(n), 32'(0));
        chk("t2_count", 32'(fifo_count), 32'(2));
        chk("t2_busy", 32'(busy), 32'(1));
        vblank = 1'b1;
        @(negedge clock); chk_wr("t2_w1", 11'd41, 4'd5); adv();
        @(negedge clock); chk_wr("t2_w2", 11'd1199, 4'd3); adv();
        @(negedge clock);
        chk("t2_after_we", 32'(smem_we), 32'(0));
        chk("t2_busy_fall", 32'(busy), 32'(0));
        adv();

        // Fill FIFO with nine back-to-back pushes
        vblank = 1'b0;
        for (int i = 0; i < 9; i++) begin
            wr_valid = 1'b1; wr_addr = ABITS'(100 + i); wr_char = CBITS'(i);
            @(negedge clock);
            rdy[i] = wr_ready;
            adv();
        end
        n = 0;
        for (int i = 0; i < 8; i++) if (rdy[i]) n++;
        chk("t3_first8_ready", 32'(n), 32'(8));
        chk("t3_ninth_refused", 32'(rdy[8]), 32'(0));
        chk("t3_count_full", 32'(fifo_count), 32'(8));
        ga.delete(); gd.delete();
        vblank = 1'b1;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clock);
            collect();
            if (c == 0) chk("t3_full_pop_refuse", 32'(wr_ready), 32'(0));
            pushed = wr_valid && wr_ready;
            adv();
            if (pushed) wr_valid = 1'b0;
            if (!busy && !wr_valid) done = 1'b1;
        end
        wr_valid = 1'b0;
        chk("t3_done", 32'(done), 32'(1));
        chk("t3_nwrites", 32'(ga.size()), 32'(9));
        errs = 0;
        for (int i = 0; i < ga.size() && i < 9; i++)
            if (ga[i] !== ABITS'(100 + i) || gd[i] !== CBITS'(i)) errs++;
        chk("t3_order", 32'(errs), 32'(0));

        // Clear with a queued write: 1200 fill writes, then the queued write
        ga.delete(); gd.delete();
        wr_valid = 1'b1; wr_addr = 11'd7; wr_char = 4'd9;
        clr_req = 1'b1; clr_char = 4'd2;
        adv();
        wr_valid = 1'b0; clr_req = 1'b0;
        done = 1'b0; busy_mid = 1'b0;
        for (int c = 0; c < 1400 && !done; c++) begin
            if (c == 10) begin clr_req = 1'b1; clr_char = 4'd5; end
            else clr_req = 1'b0;
            @(negedge clock);
            collect();
            if (c == 20) busy_mid = busy;
            adv();
            if (!busy) done = 1'b1;
        end
        clr_req = 1'b0;
        chk("t4_done", 32'(done), 32'(1));
        chk("t4_busy_mid", 32'(busy_mid), 32'(1));
        chk("t4_nwrites", 32'(ga.size()), 32'(1201));
        errs = 0;
        for (int i = 0; i < ga.size() && i < 1200; i++)
            if (ga[i] !== ABITS'(i) || gd[i] !== 4'd2) errs++;
        chk("t4_sweep", 32'(errs), 32'(0));
        last_a = '1; last_d = '1;
        if (ga.size() > 1200) begin last_a = ga[1200]; last_d = gd[1200]; end
        chk("t4_queued_after", 32'({last_a, last_d}), 32'({11'd7, 4'd9}));

        // Clear paused at counter 500 for 20 cycles
        ga.delete(); gd.delete();
        clr_req = 1'b1; clr_char = 4'd6;
        adv();
        clr_req = 1'b0;
        done = 1'b0; gap = 0; paused = 1'b0;
        for (int c = 0; c < 1400 && !done; c++) begin
            @(negedge clock);
            collect();
            pause_now = smem_we && (smem_addr == 11'd499) && !paused;
            adv();
            if (pause_now) begin
                paused = 1'b1;
                vblank = 1'b0;
                repeat (20) begin @(negedge clock); if (smem_we) gap++; adv(); end
                vblank = 1'b1;
            end
            if (!busy) done = 1'b1;
        end
        chk("t5_done", 32'(done), 32'(1));
        chk("t5_paused", 32'(paused), 32'(1));
        chk("t5_gap_writes", 32'(gap), 32'(0));
        chk("t5_nwrites", 32'(ga.size()), 32'(1200));
        errs = 0;
        for (int i = 0; i < ga.size() && i < 1200; i++)
            if (ga[i] !== ABITS'(i) || gd[i] !== 4'd6) errs++;
        chk("t5_sweep", 32'(errs), 32'(0));

        // Off-screen address is popped and discarded
        wr_valid = 1'b1; wr_addr = 11'd1200; wr_char = 4'd4;
        adv();
        wr_valid = 1'b0;
        chk("t6_count1", 32'(fifo_count), 32'(1));
        @(negedge clock); adv();
        @(negedge clock);
        chk("t6_discard_we", 32'(smem_we), 32'(0));
        adv();
        chk("t6_count0", 32'(fifo_count), 32'(0));
        chk("t6_busy", 32'(busy), 32'(0));

        // Reset mid-clear abandons the sweep and the queued write
        clr_req = 1'b1; clr_char = 4'd1;
        wr_valid = 1'b1; wr_addr = 11'd3; wr_char = 4'd3;
        adv();
        clr_req = 1'b0; wr_valid = 1'b0;
        n = 0;
        repeat (50) begin @(negedge clock); if (smem_we) n++; adv(); end
        chk("t7_clearing", 32'(n), 32'(49));
        reset = 1'b1;
        adv(); adv();
        reset = 1'b0;
        n = 0;
        repeat (20) begin @(negedge clock); if (smem_we) n++; adv(); end
        chk("t7_no_writes", 32'(n), 32'(0));
        chk("t7_busy", 32'(busy), 32'(0));
        chk("t7_count", 32'(fifo_count), 32'(0));
        chk("t7_ready", 32'(wr_ready), 32'(1));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/screen_update_controller.md
Name: screen_update_controller

Overview:
- Sequences all writes into the 40x30 character screen memory that feeds the VGA display driver.
- CPU character writes are buffered in a small FIFO and committed only while the vertical-blank indicator is high, so the display never reads a cell mid-update (no tearing).
- Also executes a whole-screen clear command that sweeps all 1200 cells with a fill character.
- Sits between the CPU memory-mapped write path and the screen memory write port; the display read port is untouched.

Parameters:
- DEPTH, 8, FIFO entries (power of 2, >=2).
- NCELLS, 1200, screen cells (40 cols x 30 rows).
- ABITS, 11, screen address width.
- CBITS, 4, character code width.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- vblank  in  1  1 = display not reading screen memory (vertical blanking).
- wr_valid  in  1  CPU write request.
- wr_ready  out  1  FIFO can accept.
- wr_addr  in  ABITS  target cell (row*40+col).
- wr_char  in  CBITS  character code.
- clr_req  in  1  one-cycle clear-screen request.
- clr_char  in  CBITS  fill character, sampled with clr_req.
- smem_we  out  1  screen memory write enable.
- smem_addr  out  ABITS  screen memory write address.
- smem_wdata  out  CBITS  screen memory write data.
- busy  out  1  clear pending or FIFO non-empty.
- fifo_count  out  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- One clock, synchronous active-high reset.
- Reset values:
  - state=IDLE; FIFO empty; fifo_count=0; clear_pending=0; clear counter=0.
  - smem_we=0, smem_addr=0, smem_wdata=0, busy=0, wr_ready=1.
  - Reset mid-clear or mid-drain abandons all pending work; queued entries are lost.
- Push: a push occurs when wr_valid && wr_ready.
  - wr_ready = !full, from registered count only.
  - A push into a full FIFO is refused even if a pop occurs in the same cycle.
  - Push and pop in the same cycle leave fifo_count unchanged.
- smem_* outputs are combinational from state, FIFO head, counter and vblank. smem_addr and smem_wdata are 0 whenever smem_we=0.
- States:
  - IDLE:
    - if clear_pending -> CLEAR;
    - else if !empty -> DRAIN.
    - No writes issued in IDLE.
  - DRAIN:
    - Each cycle with vblank=1 and !empty: pop the head.
    - smem_we=1, smem_addr=head.addr, smem_wdata=head.char.
    - Exception: if head.addr >= NCELLS, the entry is popped with smem_we=0 (silently discarded).
    - vblank=0: no pop, no write, stay in DRAIN.
    - Transitions: -> IDLE when empty after a pop; -> CLEAR at the next entry boundary if clear_pending is set (evaluated each cycle before a pop).
  - CLEAR:
    - Each cycle with vblank=1: smem_we=1, smem_addr=counter, smem_wdata=latched fill char, counter++.
    - vblank=0 pauses the sweep with counter held; a clear may span frames.
    - On the write with counter=NCELLS-1: counter<=0, clear_pending<=0, -> IDLE.
- Clear handling:
  - clr_req sets clear_pending and latches clr_char.
  - clr_req while clear_pending=1 is ignored; fill char unchanged.
  - Clear has priority over queued writes.
  - FIFO entries present before or during the clear are retained and drained after it completes, so they appear over the cleared screen.
  - Pushes during CLEAR are accepted normally.
- Write ordering: FIFO writes commit in push order. At most one screen write per cycle.
- busy = clear_pending || (fifo_count!=0).

Decomposition:
- Shared package screen_pkg holds:
  - SCREEN_COLS=40, SCREEN_ROWS=30, NCELLS=1200, ABITS=11, CBITS=4;
  - typedef enum {IDLE, DRAIN, CLEAR} suc_state_t;
  - packed struct char_wr_t {addr, char}.
- One sub-module: char_write_fifo, a synchronous FIFO with DEPTH/width parameters, push/pop, full/empty/count, and synchronous reset.

Test Plan:
- Reset with vblank=1: all outputs at reset values; no smem_we for 10 cycles.
- vblank=0, push (addr 41, char 5) and (addr 1199, char 3):
  - no smem_we while vblank=0;
  - fifo_count=2, busy=1;
  - raise vblank: smem_we in two consecutive cycles, 41/5 then 1199/3, then busy=0.
- vblank=0, push 9 entries back-to-back: first 8 accepted; wr_ready=0 on the 9th until a pop; fifo_count=8.
- clr_req with clr_char=2, vblank=1, one queued write (addr 7, char 9):
  - exactly 1200 writes of char 2 at addrs 0..1199;
  - then a write 7/9; busy falls after it.
- Clear paused at counter=500 by dropping vblank for 20 cycles: no writes during the gap; the sweep resumes at addr 500 with no gaps or duplicates.
- Push addr 1200 char 4 during vblank: entry popped, smem_we stays 0, fifo_count decrements; reset asserted mid-clear returns to IDLE with no further writes.
